// File: rtl/modulo_counter_pkg.sv
// Shared constants for the modulo counter.
// Holds only the default counter width.
package modulo_counter_pkg;
  localparam int DEFAULT_WIDTH = 20;
endpackage

// File: rtl/modulo_counter_edge_pulser.sv
// Rising-edge detector for the step request.
// Flop resets high so a level already high at release is not an edge.
module edge_pulser (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic pulse
);

  logic q;

  always_ff @(posedge clock) begin
    if (reset) q <= 1'b1;
    else       q <= d;
  end

  assign pulse = d & ~q;

endmodule

// File: rtl/modulo_counter.sv
// Up/down counter over 0..max with edge-triggered steps,
// clear/load overrides and a registered wrap pulse.
module modulo_counter
  import modulo_counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] max,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             step;
  logic [WIDTH-1:0] count_nxt;
  logic             wrap_nxt;

  edge_pulser u_edge (
    .clock (clock),
    .reset (reset),
    .d     (en),
    .pulse (step)
  );

  // Wrap test precedes +/-1, so arithmetic never leaves WIDTH bits.
  always_comb begin
    count_nxt = count;
    wrap_nxt  = 1'b0;
    priority case (1'b1)
      clear: count_nxt = '0;
      load:  count_nxt = (load_value > max) ? max : load_value;
      step & up: begin
        if (count >= max) begin
          count_nxt = '0;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count + ONE;
        end
      end
      step & ~up: begin
        if (count == '0 || count > max) begin
          count_nxt = max;
          wrap_nxt  = 1'b1;
        end else begin
          count_nxt = count - ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= count_nxt;
      wrap  <= wrap_nxt;
    end
  end

  assign at_max = (count == max);

endmodule

// File: doc/modulo_counter.md
MODULO_COUNTER -- requirements
Module: modulo_counter

Interface
REQ-001 Parameter WIDTH, default 20, sets the width of count, max and load_value; legal range 2..32.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  reset is synchronous and active-high.
REQ-004 en  input  1  step request; only a 0->1 transition causes a step.
REQ-005 up  input  1  direction: 1 = count up, 0 = count down; sampled on the step cycle.
REQ-006 clear  input  1  synchronous clear of count to 0, level-sensitive.
REQ-007 load  input  1  synchronous load of load_value, level-sensitive.
REQ-008 load_value  input  WIDTH  value written on load.
REQ-009 max  input  WIDTH  inclusive terminal value; count range is 0..max.
REQ-010 count  output  WIDTH  current count, driven directly from a register.
REQ-011 wrap  output  1  one-cycle pulse on the cycle after a wrap step.
REQ-012 at_max  output  1  combinational (count == max).

Function
REQ-013 The block SHALL register en every cycle into en_prev; a step occurs on the edge where en=1 and en_prev=0.
REQ-014 Holding en high SHALL produce exactly one step; en pulses of one cycle or longer SHALL each produce one step.
REQ-015 Latency: count SHALL show the new value immediately after the clock edge at which the step is detected.
REQ-016 Up step: if count >= max, count SHALL become 0 and wrap SHALL pulse; otherwise count SHALL increment by 1.
REQ-017 Down step: if count == 0 or count > max, count SHALL become max and wrap SHALL pulse; otherwise count SHALL decrement by 1.
REQ-018 Priority, highest first: reset, clear, load, step.
REQ-019 Clear SHALL set count to 0 with no wrap pulse.
REQ-020 Load SHALL set count to min(load_value, max) with no wrap pulse.
REQ-021 A step coinciding with clear or load SHALL be discarded, not deferred.
REQ-022 en_prev SHALL update regardless of clear or load.
REQ-023 wrap SHALL be 0 on every cycle except the one following a wrap step; it SHALL never be high for two consecutive cycles from a single step.
REQ-024 max = 0: count SHALL stay 0 and every step SHALL pulse wrap, in either direction.
REQ-025 Lowering max below count SHALL leave count unchanged until the next step, which wraps per REQ-016/017.
REQ-026 Arithmetic SHALL be modulo 2^WIDTH-free; no intermediate value may exceed WIDTH bits, and no overflow path is permitted, because the wrap rule precedes the increment.

Reset
REQ-027 On reset: count = 0, wrap = 0, en_prev = 1, so en already high at reset release does not step.
REQ-028 Reset asserted mid-operation SHALL override any simultaneous clear, load or step in that cycle.

Structure
REQ-029 The shared package SHALL hold the default WIDTH constant (20) only; there are no typedefs.
REQ-030 The rising-edge detector SHALL be one sub-module, edge_pulser (ports clock, reset, d, pulse), with its flop reset to 1.
REQ-031 The remainder SHALL be flat registers plus next-state logic; the target size is 120-250 lines of RTL.

Verification (WIDTH=4 unless stated)
REQ-032 Scenario: reset held 2 cycles with en=1, then release with en still 1 -> count=0, wrap=0, no step until en falls and rises again.
REQ-033 Scenario: max=3, up=1, 5 en pulses -> count 1,2,3,0,1; wrap high exactly on the cycle after the 4th step.
REQ-034 Scenario: max=3, up=0, starting from 0, 3 en pulses -> count 3,2,1; wrap pulses after the 1st step only.
REQ-035 Scenario: count=2, load_value=9, max=5, load=1 together with an en edge -> count=5, wrap=0, step discarded.
REQ-036 Scenario: count=7, max changed to 4, up=1, one step -> count=0, wrap=1; then clear and step together -> count=0, wrap=0.
REQ-037 Scenario: WIDTH=20, max=20'hFFFFF, load 20'hFFFFE, 2 up steps -> count FFFFF then 0, at_max high between them, wrap on the second step.
